mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-stage consumer of the EX/M pipeline buffer outputs. Each cycle it takes the buffered instruction fields, performs any load or store against the data memory through a req/ack port, and presents results to the MEM/WB buffer. While a memory access is outstanding it holds the upstream pipeline with `stall`, and it aborts the access after a bounded wait.

## Interface
- `TIMEOUT`, default 16: maximum cycles `mem_req` waits for `mem_ack` before abort (≥2).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mWrite`, `mRead`, `mByte` in 1 each: store, load, byte-access from EX/M buffer.
- `rWrite` in 2: register-write control, passed through.
- `op1`, `op2` in 4 each: register numbers, passed through.
- `data1` in 16: ALU result; memory byte address for loads/stores.
- `op1data` in 16: store data.
- `op2data` in 16: passed through.
- `r15data` in 16: passed through.
- `stall` out 1: upstream must hold its outputs.
- `mem_req` out 1: memory request.
- `mem_we` out 1: request is a write.
- `mem_be` out 2: byte enables; bit0 = bits[7:0], bit1 = bits[15:8].
- `mem_addr` out 16: word-aligned address (`data1` with bit0 cleared).
- `mem_wdata` out 16: write data.
- `mem_ack` in 1: memory completion, valid only while `mem_req`=1.
- `mem_rdata` in 16: read data, valid with `mem_ack`.
- `wb_valid` out 1: wb_* fields hold a retired instruction this cycle.
- `wb_rWrite` out 2, `wb_op1`/`wb_op2` out 4, `wb_data`/`wb_op2data`/`wb_r15data` out 16: fields for MEM/WB.
- `align_err`, `mem_err` out 1 each: one-cycle error pulses.

## Operation
- The FSM has two states, IDLE and REQ. The wb_* outputs, `wb_valid`, the error pulses and the memory outputs are all registered.
- `stall` = (state == REQ). It is combinational.
- **IDLE, no memory op** (`mRead`=`mWrite`=0):
  - At the edge, copy the inputs to wb_*, set `wb_data`=`data1`, `wb_valid`=1.
  - Stay in IDLE.
- **IDLE, memory op:**
  - Latch all fields and go to REQ.
  - Drive `mem_req`=1. `mem_we`=`mWrite`; when both `mWrite` and `mRead` are set, the write wins and the read is dropped.
  - `wb_valid`=0 during REQ.
- **Byte lanes:** `data1[0]`=0 selects lane 0, `data1[0]`=1 selects lane 1.
  - Byte store: `mem_be` has one bit set, and `op1data[7:0]` is replicated to both bytes of `mem_wdata`.
  - Word store: `mem_be`=2'b11, `mem_wdata`=`op1data`.
  - Loads drive `mem_be` the same way.
- **Misaligned word** (`mByte`=0, `data1[0]`=1, memory op):
  - No request is issued and the FSM stays in IDLE.
  - `align_err`=1 for one cycle.
  - `wb_valid`=1 with `wb_rWrite` forced to 0.
- **REQ, `mem_ack` sampled 1:**
  - Load: `wb_data` = the selected byte extended (see Configuration), or `mem_rdata` for a word load.
  - Store: `wb_data`=`data1`.
  - Latched fields go to wb_*, `wb_valid`=1, and the FSM returns to IDLE with `mem_req`=0.
- **REQ timeout:** a wait counter runs from 1 upward in REQ. If it reaches `TIMEOUT` with no ack:
  - `mem_req` drops and `mem_err`=1 for one cycle.
  - `wb_valid`=1 with `wb_rWrite`=0, and the FSM returns to IDLE.
  - A late `mem_ack` arriving in IDLE is ignored.

## Timing
- **Reset values:** state IDLE, `stall`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, all wb_*=0, `wb_valid`=0, `align_err`=0, `mem_err`=0, wait counter 0.
- **Reset mid-REQ:** at that edge the FSM returns to IDLE and `mem_req` drops. Any ack in the same cycle is discarded and no wb output is produced.
- **Non-memory op:** 1-cycle latency from input to wb_*.
- **Memory op:**
  - Captured at edge E0, so `mem_req`=1 and `stall`=1 after E0.
  - If `mem_ack`=1 is sampled at edge E0+k (k≥1), the wb_* result is valid after E0+k and `stall` is 0 after E0+k.
  - Upstream holds the next instruction from E0 through E0+k. That instruction is captured at E0+k+1.
- **Back-to-back memory ops:** one idle `mem_req`=0 cycle between requests.
- **Timeout:** after E0+`TIMEOUT` with no ack, the same sequence as an acked access applies, except with the error outcome.
- **Stability:** `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` stay stable for the whole time `mem_req` is high.

## Configuration
- `MEM_BYTE_SIGNEXT_EN` defined: byte loads are sign-extended from bit 7 of the selected byte.
- `MEM_BYTE_SIGNEXT_EN` undefined: byte loads are zero-extended.
- Stores and word loads behave the same either way.

## Test plan
- **Non-memory op:** `rWrite`=01, `op1`=1, `data1`=00A0 → next cycle `wb_valid`=1, `wb_data`=00A0, `wb_rWrite`=01; `stall` stays 0.
- **Word load:** `mRead`=1, `data1`=0010, ack on the 3rd REQ cycle with `mem_rdata`=BEEF → `mem_addr`=0010, `mem_be`=11, `stall` high for 3 cycles, then `wb_data`=BEEF.
- **Byte load:**
  - Setup: `mByte`=1, `data1`=0011, `mem_rdata`=90CC.
  - With the macro: `wb_data`=FF90. Without the macro: `wb_data`=0090.
  - `mem_be`=10 in both cases.
- **Byte store with both writes set:** `mWrite`=`mRead`=1, `mByte`=1, `data1`=0000, `op1data`=12CC → `mem_we`=1, `mem_be`=01, `mem_wdata`=CCCC; the read is dropped.
- **Misaligned word:** word op at `data1`=0001 → `align_err` pulses, `mem_req` never asserts, `wb_rWrite`=00.
- **Timeout and reset:**
  - No ack with `TIMEOUT`=16 → `mem_err` pulses 16 cycles after capture and `stall` drops.
  - A separate run asserts `rst` on REQ cycle 2 → `mem_req`=0 and `wb_valid`=0 on the next cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage between the EX/M and MEM/WB pipeline buffers.
// Takes the buffered instruction fields, performs loads/stores over a req/ack
// data-memory port, and presents retired results on the wb_* outputs. Holds
// upstream with stall while a request is outstanding and aborts after TIMEOUT
// cycles without an ack.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mWrite/mRead/mByte       store / load / byte-access controls
//   rWrite, op1, op2         register-write control and register numbers
//   data1                    ALU result, byte address for memory ops
//   op1data                  store data
//   op2data, r15data         passed through to wb_*
//   stall                    combinational, high while in REQ
//   mem_req/we/be/addr/wdata data-memory request (registered, stable while req)
//   mem_ack, mem_rdata       data-memory completion and read data
//   wb_*                     MEM/WB fields, wb_valid marks a retired instruction
//   align_err, mem_err       one-cycle error pulses (misaligned word, timeout)
//
// Build option: MEM_BYTE_SIGNEXT_EN sign-extends byte loads (zero-extend otherwise).
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mWrite,
  input  logic        mRead,
  input  logic        mByte,
  input  logic [1:0]  rWrite,
  input  logic [3:0]  op1,
  input  logic [3:0]  op2,
  input  logic [15:0] data1,
  input  logic [15:0] op1data,
  input  logic [15:0] op2data,
  input  logic [15:0] r15data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        wb_valid,
  output logic [1:0]  wb_rWrite,
  output logic [3:0]  wb_op1,
  output logic [3:0]  wb_op2,
  output logic [15:0] wb_data,
  output logic [15:0] wb_op2data,
  output logic [15:0] wb_r15data,
  output logic        align_err,
  output logic        mem_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, REQ} state_t;

  // Instruction fields held while the access is outstanding
  typedef struct packed {
    logic [1:0]  rwrite;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [15:0] data1;
    logic [15:0] op2data;
    logic [15:0] r15data;
    logic        mbyte;
  } fields_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fields_t       fld_q, fld_d;

  logic        mem_req_d, mem_we_d, wb_valid_d, align_err_d, mem_err_d;
  logic [1:0]  mem_be_d, wb_rwrite_d;
  logic [3:0]  wb_op1_d, wb_op2_d;
  logic [15:0] mem_addr_d, mem_wdata_d, wb_data_d, wb_op2data_d, wb_r15data_d;
  logic [7:0]  rd_byte;
  logic [15:0] ld_byte;

  assign stall = (state_q == REQ);

  // Byte lane selected by the latched address bit 0
  always_comb begin
    rd_byte = fld_q.data1[0] ? mem_rdata[15:8] : mem_rdata[7:0];
`ifdef MEM_BYTE_SIGNEXT_EN
    ld_byte = {{8{rd_byte[7]}}, rd_byte};
`else
    ld_byte = {8'h00, rd_byte};
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fld_d        = fld_q;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_be_d     = mem_be;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    wb_valid_d   = 1'b0;
    wb_rwrite_d  = wb_rWrite;
    wb_op1_d     = wb_op1;
    wb_op2_d     = wb_op2;
    wb_data_d    = wb_data;
    wb_op2data_d = wb_op2data;
    wb_r15data_d = wb_r15data;
    align_err_d  = 1'b0;
    mem_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if ((mRead || mWrite) && !(!mByte && data1[0])) begin
          state_d     = REQ;
          cnt_d       = CW'(1);
          fld_d       = '{rwrite: rWrite, op1: op1, op2: op2, data1: data1,
                          op2data: op2data, r15data: r15data, mbyte: mByte};
          mem_req_d   = 1'b1;
          mem_we_d    = mWrite;  // write wins over a simultaneous read
          mem_be_d    = mByte ? (data1[0] ? 2'b10 : 2'b01) : 2'b11;
          mem_addr_d  = {data1[15:1], 1'b0};
          mem_wdata_d = mWrite ? (mByte ? {2{op1data[7:0]}} : op1data) : 16'h0000;
        end else begin
          // Non-memory op retires directly; misaligned word retires without write-back
          wb_valid_d   = 1'b1;
          wb_rwrite_d  = (mRead || mWrite) ? 2'b00 : rWrite;
          wb_op1_d     = op1;
          wb_op2_d     = op2;
          wb_data_d    = data1;
          wb_op2data_d = op2data;
          wb_r15data_d = r15data;
          align_err_d  = mRead || mWrite;
        end
      end
      REQ: begin
        if (mem_ack || (cnt_q == CW'(TIMEOUT))) begin
          state_d      = IDLE;
          cnt_d        = '0;
          mem_req_d    = 1'b0;
          wb_valid_d   = 1'b1;
          wb_rwrite_d  = mem_ack ? fld_q.rwrite : 2'b00;
          wb_op1_d     = fld_q.op1;
          wb_op2_d     = fld_q.op2;
          wb_op2data_d = fld_q.op2data;
          wb_r15data_d = fld_q.r15data;
          mem_err_d    = !mem_ack;
          if (mem_ack && !mem_we) begin
            wb_data_d = fld_q.mbyte ? ld_byte : mem_rdata;
          end else begin
            wb_data_d = fld_q.data1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fld_q      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 2'b00;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      wb_valid   <= 1'b0;
      wb_rWrite  <= 2'b00;
      wb_op1     <= 4'h0;
      wb_op2     <= 4'h0;
      wb_data    <= 16'h0000;
      wb_op2data <= 16'h0000;
      wb_r15data <= 16'h0000;
      align_err  <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fld_q      <= fld_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_be     <= mem_be_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      wb_valid   <= wb_valid_d;
      wb_rWrite  <= wb_rwrite_d;
      wb_op1     <= wb_op1_d;
      wb_op2     <= wb_op2_d;
      wb_data    <= wb_data_d;
      wb_op2data <= wb_op2data_d;
      wb_r15data <= wb_r15data_d;
      align_err  <= align_err_d;
      mem_err    <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage: non-memory op, word/byte loads,
// byte store with both controls set, back-to-back requests, misaligned word,
// timeout with late ack, and reset during a request.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mWrite, mRead, mByte;
  logic [1:0]  rWrite;
  logic [3:0]  op1, op2;
  logic [15:0] data1, op1data, op2data, r15data;
  logic        stall, mem_req, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic [1:0]  wb_rWrite;
  logic [3:0]  wb_op1, wb_op2;
  logic [15:0] wb_data, wb_op2data, wb_r15data;
  logic        align_err, mem_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .mWrite(mWrite), .mRead(mRead), .mByte(mByte),
    .rWrite(rWrite), .op1(op1), .op2(op2),
    .data1(data1), .op1data(op1data), .op2data(op2data), .r15data(r15data),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rWrite(wb_rWrite), .wb_op1(wb_op1), .wb_op2(wb_op2),
    .wb_data(wb_data), .wb_op2data(wb_op2data), .wb_r15data(wb_r15data),
    .align_err(align_err), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    mWrite = 1'b0; mRead = 1'b0; mByte = 1'b0;
    rWrite = 2'b00; op1 = 4'h0; op2 = 4'h0;
    data1 = 16'h0000; op1data = 16'h0000; op2data = 16'h0000; r15data = 16'h0000;
  endtask

  int stall_cnt;
  int n;
  logic unstable;
  logic [15:0] exp_byte;

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
    set_nop();
    tick(); tick();

    // Reset state
    check("rst_stall",   32'(stall), 32'h0);
    check("rst_req",     32'(mem_req), 32'h0);
    check("rst_wbvalid", 32'(wb_valid), 32'h0);
    check("rst_be",      32'(mem_be), 32'h0);
    check("rst_wbdata",  32'(wb_data), 32'h0);
    rst = 1'b0;

    // Non-memory op: one-cycle pass-through
    rWrite = 2'b01; op1 = 4'd1; op2 = 4'd2; data1 = 16'h00A0;
    op2data = 16'h1111; r15data = 16'h2222;
    tick();
    check("nop_valid",   32'(wb_valid), 32'h1);
    check("nop_data",    32'(wb_data), 32'h00A0);
    check("nop_rwrite",  32'(wb_rWrite), 32'h1);
    check("nop_op1",     32'(wb_op1), 32'h1);
    check("nop_op2data", 32'(wb_op2data), 32'h1111);
    check("nop_stall",   32'(stall), 32'h0);
    set_nop();
    tick();

    // Word load, ack sampled at end of the third REQ cycle
    mRead = 1'b1; data1 = 16'h0010; rWrite = 2'b10; op1 = 4'd3; r15data = 16'h3333;
    tick();
    check("wl_req",  32'(mem_req), 32'h1);
    check("wl_addr", 32'(mem_addr), 32'h0010);
    check("wl_be",   32'(mem_be), 32'h3);
    check("wl_we",   32'(mem_we), 32'h0);
    check("wl_wbv",  32'(wb_valid), 32'h0);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_cnt++;
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      tick();
    end
    mem_ack = 1'b0;
    set_nop();
    check("wl_stallcyc", 32'(stall_cnt), 32'd3);
    check("wl_stall",    32'(stall), 32'h0);
    check("wl_req_off",  32'(mem_req), 32'h0);
    check("wl_wbv2",     32'(wb_valid), 32'h1);
    check("wl_data",     32'(wb_data), 32'hBEEF);
    check("wl_rwrite",   32'(wb_rWrite), 32'h2);
    check("wl_r15",      32'(wb_r15data), 32'h3333);
    tick();

    // Byte load from lane 1
    mRead = 1'b1; mByte = 1'b1; data1 = 16'h0011; rWrite = 2'b01;
    tick();
    set_nop();
    check("bl_be",   32'(mem_be), 32'h2);
    check("bl_addr", 32'(mem_addr), 32'h0010);
    mem_ack = 1'b1; mem_rdata = 16'h90CC;
    tick();
    mem_ack = 1'b0;
`ifdef MEM_BYTE_SIGNEXT_EN
    exp_byte = 16'hFF90;
`else
    exp_byte = 16'h0090;
`endif
    check("bl_data", 32'(wb_data), 32'(exp_byte));
    check("bl_wbv",  32'(wb_valid), 32'h1);
    tick();

    // Byte store with both write and read set, then a back-to-back request
    mWrite = 1'b1; mRead = 1'b1; mByte = 1'b1; data1 = 16'h0000; op1data = 16'h12CC;
    tick();
    check("bs_we",    32'(mem_we), 32'h1);
    check("bs_be",    32'(mem_be), 32'h1);
    check("bs_wdata", 32'(mem_wdata), 32'hCCCC);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    check("bs_data",  32'(wb_data), 32'h0000);
    check("bs_gap",   32'(mem_req), 32'h0);
    tick();
    check("b2b_req",  32'(mem_req), 32'h1);
    set_nop();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("b2b_done", 32'(mem_req), 32'h0);
    tick();

    // Misaligned word access
    mRead = 1'b1; data1 = 16'h0001; rWrite = 2'b11;
    tick();
    set_nop();
    check("mis_err",    32'(align_err), 32'h1);
    check("mis_req",    32'(mem_req), 32'h0);
    check("mis_wbv",    32'(wb_valid), 32'h1);
    check("mis_rwrite", 32'(wb_rWrite), 32'h0);
    check("mis_stall",  32'(stall), 32'h0);
    tick();
    check("mis_pulse",  32'(align_err), 32'h0);

    // Timeout with no ack, then a late ack in IDLE
    mRead = 1'b1; data1 = 16'h0020; rWrite = 2'b01;
    tick();
    set_nop();
    n = 0; unstable = 1'b0;
    while (!mem_err && n < 40) begin
      if (mem_addr != 16'h0020 || !mem_req || !stall) unstable = 1'b1;
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_stable", 32'(unstable), 32'h0);
    check("to_req",    32'(mem_req), 32'h0);
    check("to_stall",  32'(stall), 32'h0);
    check("to_wbv",    32'(wb_valid), 32'h1);
    check("to_rwrite", 32'(wb_rWrite), 32'h0);
    data1 = 16'h0777; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check("to_pulse",  32'(mem_err), 32'h0);
    check("late_ack",  32'(wb_data), 32'h0777);
    check("late_req",  32'(mem_req), 32'h0);
    set_nop();
    tick();

    // Reset asserted on REQ cycle 2, with an ack in the same cycle
    mRead = 1'b1; data1 = 16'h0030;
    tick();
    set_nop();
    tick();
    check("rr_stall_pre", 32'(stall), 32'h1);
    rst = 1'b1; mem_ack = 1'b1;
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    check("rr_req",   32'(mem_req), 32'h0);
    check("rr_wbv",   32'(wb_valid), 32'h0);
    check("rr_stall", 32'(stall), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
